// File: rtl/missle_sched.sv
// missle_sched: round-robin fire scheduler with refire cooldown (define MISSLE_SCHED_AUTOFIRE_EN for hold-to-autofire)
module missle_sched #(
    parameter int N_SLOTS = 4,
    parameter int COOLDOWN_CYCLES = 1000000
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               fire_btn,
    input  logic [N_SLOTS-1:0] slot_busy,
    output logic [N_SLOTS-1:0] launch,
    output logic               denied,
    output logic               ready,
    output logic [15:0]        shot_count
);
    localparam int PW = $clog2(N_SLOTS);
    localparam logic [PW:0] NS = (PW+1)'(N_SLOTS);
    typedef enum logic {READY, COOLDOWN} state_t;
    state_t state, state_n;
    logic btn_q, req, any_free, denied_n;
    logic [PW-1:0] rr_ptr, rr_ptr_n, pick, off;
    logic [PW:0] sum, nxt;
    logic [23:0] cd_cnt, cd_cnt_n;
    logic [N_SLOTS-1:0] resv, free, launch_n;
    logic [2*N_SLOTS-1:0] rot;
    logic [1:0] age [N_SLOTS];

`ifdef MISSLE_SCHED_AUTOFIRE_EN
    // high only during the first READY cycle after a cooldown, re-arming a held button
    logic ready_hold;
    always_ff @(posedge pclk) ready_hold <= !rst && state == COOLDOWN && cd_cnt == '0;
    assign req = fire_btn & (~btn_q | ready_hold);
`else
    assign req = fire_btn & ~btn_q;
`endif

    assign free = ~slot_busy & ~resv;
    assign any_free = |free;
    assign ready = state == READY;
    assign rot = {free, free} >> rr_ptr;

    always_comb begin
        off = '0;
        for (int k = N_SLOTS-1; k >= 0; k--)
            if (rot[k]) off = PW'(k);
        sum = {1'b0, rr_ptr} + {1'b0, off};
        pick = PW'(sum >= NS ? sum - NS : sum);
        nxt = {1'b0, pick} + 1'b1;
    end

    always_comb begin
        state_n = state;
        rr_ptr_n = rr_ptr;
        cd_cnt_n = cd_cnt;
        launch_n = '0;
        denied_n = 1'b0;
        if (state == READY) begin
            if (req && any_free) begin
                launch_n = N_SLOTS'(1) << pick;
                rr_ptr_n = nxt == NS ? '0 : PW'(nxt);
                cd_cnt_n = 24'(COOLDOWN_CYCLES - 1);
                state_n = COOLDOWN;
            end else begin
                denied_n = req;
            end
        end else begin
            cd_cnt_n = cd_cnt == '0 ? '0 : cd_cnt - 1'b1;
            state_n = cd_cnt == '0 ? READY : COOLDOWN;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= READY;
            btn_q <= 1'b1;
            rr_ptr <= '0;
            cd_cnt <= '0;
            launch <= '0;
            denied <= 1'b0;
            shot_count <= '0;
        end else begin
            state <= state_n;
            btn_q <= fire_btn;
            rr_ptr <= rr_ptr_n;
            cd_cnt <= cd_cnt_n;
            launch <= launch_n;
            denied <= denied_n;
            shot_count <= shot_count + 16'(|launch_n);
        end
    end

    // reservation bridges the controller's on-flag latency: held until busy is seen or 3 cycles pass
    always_ff @(posedge pclk) begin
        if (rst) begin
            resv <= '0;
            age <= '{default: '0};
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (launch_n[i]) begin
                    resv[i] <= 1'b1;
                    age[i] <= '0;
                end else if (resv[i]) begin
                    resv[i] <= !(slot_busy[i] || age[i] == 2'd2);
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_missle_sched.sv
// tb_missle_sched: directed checks of missle_sched with N_SLOTS=4, COOLDOWN_CYCLES=8
module tb_missle_sched;
    logic pclk = 1'b0, rst = 1'b1, fire_btn = 1'b1, mirror = 1'b1;
    logic [3:0] busy_force = '0, slot_busy, launch, l1 = '0, l2 = '0;
    logic denied, ready;
    logic [15:0] shot_count;
    int tests = 0, fails = 0;

    missle_sched #(.N_SLOTS(4), .COOLDOWN_CYCLES(8)) dut (
        .pclk(pclk), .rst(rst), .fire_btn(fire_btn), .slot_busy(slot_busy),
        .launch(launch), .denied(denied), .ready(ready), .shot_count(shot_count)
    );

    always #5 pclk = ~pclk;
    // flight controllers raise their on-flag two cycles after launch
    always @(posedge pclk) begin
        l1 <= launch;
        l2 <= l1;
    end
    assign slot_busy = mirror ? l2 : busy_force;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        step(3);
        chk("rst_launch", launch, 0);
        chk("rst_denied", denied, 0);
        chk("rst_ready", ready, 1);
        chk("rst_shot", shot_count, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("held_no_launch", launch, 0);
        end
        fire_btn = 1'b0;
        step(1);
        chk("release_no_launch", launch, 0);
        for (int i = 0; i < 4; i++) begin
            fire_btn = 1'b1;
            step(1);
            chk("rr_launch", launch, 32'd1 << i);
            chk("rr_ready_low", ready, 0);
            chk("rr_shot", shot_count, i + 1);
            fire_btn = 1'b0;
            step(1);
            chk("rr_pulse_end", launch, 0);
            step(8);
        end
        fire_btn = 1'b1;
        step(1);
        chk("cd_launch", launch, 4'b0001);
        fire_btn = 1'b0;
        step(3);
        fire_btn = 1'b1;
        step(1);
        chk("cd_discard_launch", launch, 0);
        chk("cd_discard_denied", denied, 0);
        fire_btn = 1'b0;
        step(3);
        chk("cd_ready_low", ready, 0);
        fire_btn = 1'b1;
        step(1);
        chk("cd_ready_back", ready, 1);
        chk("cd_zero_discard", launch, 0);
        chk("cd_zero_no_deny", denied, 0);
        fire_btn = 1'b0;
        step(1);
        chk("cd_after", launch, 0);
        chk("cd_shot", shot_count, 5);
        mirror = 1'b0;
        busy_force = 4'b1111;
        step(2);
        fire_btn = 1'b1;
        step(1);
        chk("deny_pulse", denied, 1);
        chk("deny_launch", launch, 0);
        chk("deny_ready", ready, 1);
        chk("deny_shot", shot_count, 5);
        fire_btn = 1'b0;
        step(1);
        chk("deny_one_cycle", denied, 0);
        busy_force = 4'b0101;
        fire_btn = 1'b1;
        step(1);
        chk("skip_busy_0101", launch, 4'b0010);
        fire_btn = 1'b0;
        step(9);
        busy_force = 4'b0111;
        fire_btn = 1'b1;
        step(1);
        chk("skip_busy_0111", launch, 4'b1000);
        chk("skip_shot", shot_count, 7);
        fire_btn = 1'b0;
        step(9);
        busy_force = 4'b0000;
        mirror = 1'b1;
        fire_btn = 1'b1;
        step(1);
        chk("wrap_ptr_launch", launch, 4'b0001);
        chk("wrap_ptr_shot", shot_count, 8);
        rst = 1'b1;
        fire_btn = 1'b0;
        step(1);
        chk("midrst_launch", launch, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_shot", shot_count, 0);
        chk("midrst_denied", denied, 0);
        step(1);
        rst = 1'b0;
        step(2);
        fire_btn = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step(1);
`ifdef MISSLE_SCHED_AUTOFIRE_EN
            chk("hold_launch", launch, ((c - 1) % 9 == 0) ? (32'd1 << (((c - 1) / 9) % 4)) : 32'd0);
`else
            chk("hold_launch", launch, (c == 1) ? 32'd1 : 32'd0);
`endif
        end
`ifdef MISSLE_SCHED_AUTOFIRE_EN
        chk("hold_shot", shot_count, 5);
`else
        chk("hold_shot", shot_count, 1);
`endif
        fire_btn = 1'b0;
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/missle_sched.md
# missle_sched

Fire-request scheduler sitting between the debounced player fire button and a bank of `N_SLOTS` missile-flight controllers. It turns button presses into one-cycle launch pulses and shares the slots round-robin among successive shots. It enforces a refire cooldown and reports shots issued or denied to the score/HUD logic. Each `launch[i]` drives the fire input of flight controller *i*. Each controller's on-flag returns as `slot_busy[i]`.

## Interface
Parameters:
- `N_SLOTS`, 4: number of missile-flight controllers; range 2..8.
- `COOLDOWN_CYCLES`, 1000000: minimum pclk cycles between consecutive launches; must be ≥ 4 and < 2^24.

Ports:
- `pclk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `fire_btn`  in  1  debounced fire button level, synchronous to pclk.
- `slot_busy`  in  N_SLOTS  per-slot in-flight flag from the flight controllers.
- `launch`  out  N_SLOTS  one-hot, one-cycle launch pulse.
- `denied`  out  1  one-cycle pulse: a fire request was seen but every slot was busy.
- `ready`  out  1  high in READY state (cooldown expired).
- `shot_count`  out  16  launches issued since reset; wraps at 65535→0.

## Operation
- Edge detect: `btn_q` holds the previous `fire_btn`. A request is `fire_btn & ~btn_q`; the `MISSLE_SCHED_AUTOFIRE_EN` section below modifies this.
- Free mask: `free = ~slot_busy & ~resv`. `resv[i]` is set when slot *i* launches. It clears when `slot_busy[i]` is first sampled high, or after 3 cycles, whichever is first. This covers the controller's 2-cycle on-flag latency.
- Slot pick: search `free` starting at `rr_ptr` and wrapping upward; take the first set bit.
- FSM, 2 states:
  - READY: on a request with `free != 0`, register `launch[pick]=1`, increment `shot_count`, set `rr_ptr = (pick+1) mod N_SLOTS`, load `cd_cnt = COOLDOWN_CYCLES-1`, then go to COOLDOWN.
  - READY: on a request with `free == 0`, pulse `denied` and stay in READY.
  - COOLDOWN: decrement `cd_cnt` every cycle. At `cd_cnt == 0`, go to READY. Requests arriving here are discarded silently: no `denied`, no queuing.
- `launch` and `denied` are never high in the same cycle. `launch` is never multi-hot.
- `slot_busy` changes have no effect on the FSM except through `free`.

## Timing
- Reset values:
  - `launch=0`, `denied=0`, `ready=1`, `shot_count=0`.
  - state=READY, `rr_ptr=0`, `cd_cnt=0`, `resv=0`.
  - `btn_q=1`, so a button held through reset does not fire at reset release.
- Latency: a rising edge of `fire_btn` sampled at cycle t produces `launch` (or `denied`) high during cycle t+1 only.
- `ready` falls at t+1 together with `launch`. It rises again at t+1+COOLDOWN_CYCLES, so the next launch comes no sooner than COOLDOWN_CYCLES cycles after the previous one.
- Reset asserted mid-COOLDOWN or mid-pulse: all outputs reach reset values on the next edge. In-flight `resv` bits are dropped.
- Request on the same cycle that `cd_cnt` reaches 0: discarded, because the state is still COOLDOWN.
- `shot_count` wraps 0xFFFF→0x0000 on the next launch.

## Configuration
- `MISSLE_SCHED_AUTOFIRE_EN` defined: request = `fire_btn & (~btn_q | ready_hold)`. `ready_hold` is set on the first READY cycle while `fire_btn` is high. Holding the button therefore fires again each time the cooldown expires, one shot per COOLDOWN_CYCLES+1 cycles. With all slots busy while held, `denied` pulses at most once per cooldown period.
- Not defined: edge-triggered only; a held button yields exactly one request.

## Test plan
Benches use N_SLOTS=4 and COOLDOWN_CYCLES=8.
- Reset with `fire_btn` held high, then release reset -> no `launch` until the button goes 0 then 1; `ready=1`, `shot_count=0`.
- Four presses spaced 10 cycles apart, all slots idle, `slot_busy` mirroring `launch` with 2-cycle delay -> `launch` = 0001, 0010, 0100, 1000; each pulse one cycle after its press edge; `shot_count=4`.
- Press at t=0, second press at t=4 -> one `launch` at t=1, second press discarded, no `denied`; `ready` high again at t=9.
- `slot_busy=1111`, press -> `denied` high for exactly one cycle, `launch=0`, state stays READY, `shot_count` unchanged.
- `slot_busy=0101`, `rr_ptr=1` -> `launch=0010`; next press with `slot_busy=0111` -> `launch=1000`.
- `MISSLE_SCHED_AUTOFIRE_EN` build, button held for 40 cycles with slots idle -> launches at t=1, 10, 19, 28, 37, rotating through slots 0, 1, 2, 3, 0.
